adxl362_spi_master: RTL and testbench
=====================================

ADXL362_SPI_MASTER -- requirements
Module: adxl362_spi_master

Interface
- REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
- REQ-002 SHALL have port clk, input, 1: system clock; all logic on posedge clk.
- REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-004 SHALL have port start, input, 1: transaction request; sampled only in IDLE.
- REQ-005 SHALL have port cmd_write, input, 1: selects the command byte; 1 = 0x0A register write, 0 = 0x0B register read.
- REQ-006 SHALL have port addr, input, 8: register address.
- REQ-007 SHALL have port wdata, input, 8: write data byte.
- REQ-008 SHALL have port len, input, 4: read burst length in bytes; 0 treated as 1; ignored for writes.
- REQ-009 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
- REQ-010 SHALL have port rdata, output, 8: last received read byte.
- REQ-011 SHALL have port rdata_valid, output, 1: one-cycle pulse per received read byte.
- REQ-012 SHALL have port done, output, 1: one-cycle pulse at transaction end.
- REQ-013 SHALL have port sclk, output, 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
- REQ-014 SHALL have port cs_n, output, 1: active-low chip select.
- REQ-015 SHALL have port mosi, output, 1: serial data to the accelerometer, MSB first.
- REQ-016 SHALL have port miso, input, 1: serial data from the accelerometer.

Function
- REQ-017 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on accepted start; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after the last bit; HOLD->GAP after CLK_DIV cycles; GAP->IDLE after CLK_DIV cycles.
- REQ-018 SHALL, on start in IDLE, latch cmd_write, addr, wdata and len, and drive cs_n=0 and busy=1 on the next edge.
- REQ-019 SHALL keep sclk=0 throughout SETUP, with mosi already driving the command-byte MSB.
- REQ-020 SHALL shift 8*(2+N) bits in SHIFT, in order command byte, addr, data phase; N=1 for writes, N=max(len,1) for reads.
- REQ-021 SHALL drive each bit as sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- REQ-022 SHALL sample miso on the clk edge where sclk rises, and update mosi only where sclk falls (or on SETUP entry).
- REQ-023 SHALL drive mosi from wdata during the data phase of a write, and 0 during the data phase of a read.
- REQ-024 SHALL, after the 8th sample of each read data byte, load rdata and pulse rdata_valid for exactly one cycle; rdata_valid SHALL never pulse for the command or address byte, nor for writes.
- REQ-025 SHALL, on reaching HOLD, keep sclk=0 and cs_n=0 for CLK_DIV cycles, then drive cs_n=1 for the whole of GAP.
- REQ-026 SHALL, on leaving GAP, pulse done for one cycle and drop busy on the same edge; start is accepted again from the following cycle.
- REQ-027 SHALL ignore start when not in IDLE, and SHALL ignore changes to latched inputs mid-transaction.
- REQ-028 SHALL use bit and byte counters wide enough for 17 bytes, with no wrap-around within a transaction.
- REQ-029 SHALL make cs_n low time equal (2+16*(2+N))*CLK_DIV... precisely CLK_DIV + 16*(2+N)*CLK_DIV + CLK_DIV cycles.

Reset
- REQ-030 SHALL, while rst=1, force IDLE with cs_n=1, sclk=0, mosi=0, busy=0, done=0, rdata_valid=0 and rdata=0x00.
- REQ-031 SHALL, on rst asserted mid-transaction, abort on the next edge: cs_n high, no done pulse, no rdata_valid pulse.
- REQ-032 SHALL, when start and rst are asserted together, let rst win.

Verification
- REQ-033 SHALL cover: CLK_DIV=4, write addr 0x2D, wdata 0x02 -> mosi bytes 0x0A,0x2D,0x02; 24 sclk rises; cs_n low 200 cycles; one done; no rdata_valid.
- REQ-034 SHALL cover: read addr 0x00, len=1, responder returning 0xAD -> rdata=0xAD with exactly one rdata_valid before done.
- REQ-035 SHALL cover: read addr 0x0E, len=6, responder returning 0x11..0x16 -> six rdata_valid pulses in that order; 64 sclk rises.
- REQ-036 SHALL cover: len=0 read -> identical to len=1 (24 sclk rises, one rdata_valid).
- REQ-037 SHALL cover: start pulsed mid-transfer -> ignored; exactly one done.
- REQ-038 SHALL cover: rst at the 10th sclk rise -> cs_n=1, sclk=0 next edge; no done; a subsequent write completes normally.

Source files
------------

// File: rtl/adxl362_spi_master.sv
// rtl/adxl362_spi_master.sv - SPI mode-0 master for ADXL362 register read/write bursts
module adxl362_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmd_write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [3:0] len,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       done,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  bit_q;
    logic [4:0]  byte_q;
    logic [4:0]  nbytes_q;
    logic        wr_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  tx_q;
    logic [7:0]  rx_q;
    logic        sclk_q;
    logic        cs_n_q;
    logic        mosi_q;
    logic        busy_q;
    logic        done_q;
    logic        rv_q;
    logic [7:0]  rdata_q;

    logic        phase_end_d;
    logic [7:0]  cnt_d;
    logic        last_bit_d;
    logic [7:0]  next_byte_d;
    logic [7:0]  rx_d;
    logic [7:0]  cmd_d;
    logic [3:0]  len_eff_d;
    logic [4:0]  nbytes_d;

    // Phase timing, byte sequencing and start-time decode of the request.
    always_comb begin
        phase_end_d = (cnt_q == DIV_LAST);
        cnt_d       = phase_end_d ? 8'd0 : cnt_q + 8'd1;
        last_bit_d  = (bit_q == 3'd7) && (byte_q == nbytes_q - 5'd1);
        // Byte 0 is the command, byte 1 the address, the rest are data.
        next_byte_d = (byte_q == 5'd0) ? addr_q : (wr_q ? wdata_q : 8'h00);
        rx_d        = {rx_q[6:0], miso};
        cmd_d       = cmd_write ? CMD_WRITE : CMD_READ;
        len_eff_d   = (len == 4'd0) ? 4'd1 : len;
        nbytes_d    = cmd_write ? 5'd3 : ({1'b0, len_eff_d} + 5'd2);
    end

    // Transaction FSM with all SPI pins and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            bit_q    <= 3'd0;
            byte_q   <= 5'd0;
            nbytes_q <= 5'd0;
            wr_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            rv_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SETUP;
                        wr_q     <= cmd_write;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        nbytes_q <= nbytes_d;
                        tx_q     <= cmd_d;
                        mosi_q   <= cmd_d[7];
                        cs_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        sclk_q   <= 1'b0;
                        cnt_q    <= 8'd0;
                        bit_q    <= 3'd0;
                        byte_q   <= 5'd0;
                    end
                end
                SETUP: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        if (!sclk_q) begin
                            // Rising sclk: sample miso; a full data byte goes to rdata.
                            sclk_q <= 1'b1;
                            rx_q   <= rx_d;
                            if (bit_q == 3'd7 && byte_q >= 5'd2 && !wr_q) begin
                                rdata_q <= rx_d;
                                rv_q    <= 1'b1;
                            end
                        end else begin
                            // Falling sclk: advance to the next bit or finish.
                            sclk_q <= 1'b0;
                            if (last_bit_d) begin
                                state_q <= HOLD;
                            end else if (bit_q == 3'd7) begin
                                bit_q  <= 3'd0;
                                byte_q <= byte_q + 5'd1;
                                tx_q   <= next_byte_d;
                                mosi_q <= next_byte_d[7];
                            end else begin
                                bit_q  <= bit_q + 3'd1;
                                tx_q   <= {tx_q[6:0], 1'b0};
                                mosi_q <= tx_q[6];
                            end
                        end
                    end
                end
                HOLD: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        state_q <= GAP;
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rv_q;
    assign done        = done_q;
    assign sclk        = sclk_q;
    assign cs_n        = cs_n_q;
    assign mosi        = mosi_q;

endmodule

// File: tb/tb_adxl362_spi_master.sv
// tb/tb_adxl362_spi_master.sv - randomized self-checking bench for adxl362_spi_master
module tb_adxl362_spi_master;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cmd_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] len;
    logic       busy;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       done;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;

    always #5 clk = ~clk;

    adxl362_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd_write  (cmd_write),
        .addr       (addr),
        .wdata      (wdata),
        .len        (len),
        .busy       (busy),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .done       (done),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: accumulates counts and logs; only deltas are used per transaction.
    int   n_rise   = 0;
    int   n_cslow  = 0;
    int   n_done   = 0;
    int   n_rv     = 0;
    int   n_glitch = 0;
    logic prev_sclk = 1'b0;
    logic [7:0] rv_log[$];
    logic       mosi_log[$];

    always @(negedge clk) begin
        if (cs_n === 1'b0) n_cslow++;
        if (done === 1'b1) n_done++;
        if (rdata_valid === 1'b1) begin
            n_rv++;
            rv_log.push_back(rdata);
        end
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            n_rise++;
            mosi_log.push_back(mosi);
        end else if (sclk === 1'b1 && prev_sclk === 1'b1 && mosi_log.size() > 0) begin
            if (mosi !== mosi_log[$]) n_glitch++;
        end
        prev_sclk = sclk;
    end

    // Accelerometer model: presents bit k of its byte stream after the k-th sclk fall.
    logic [7:0] resp [0:16];
    int         fall_cnt = 0;
    logic [7:0] cur_byte;

    always @(negedge sclk or posedge cs_n) begin
        if (cs_n === 1'b1) fall_cnt = 0;
        else fall_cnt++;
    end

    always @* begin
        cur_byte = (fall_cnt < 136) ? resp[fall_cnt / 8] : 8'h00;
        miso     = cur_byte[3'(7 - (fall_cnt % 8))];
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           input logic [3:0] l, input bit fixed, input logic [7:0] base,
                           input bit poke, input string tag);
        int         n;
        int         nb;
        int         r0, c0, d0, v0, q0, g0;
        int         nrv;
        bit         seen;
        logic [7:0] exp_b [0:16];
        logic [7:0] got;
        n  = wr ? 1 : ((l == 4'd0) ? 1 : int'(l));
        nb = 2 + n;
        for (int i = 0; i < 17; i++) resp[i] = 8'($urandom);
        if (fixed) begin
            for (int i = 0; i < n; i++) resp[2 + i] = base + 8'(i);
        end
        exp_b[0] = wr ? 8'h0A : 8'h0B;
        exp_b[1] = a;
        for (int i = 2; i < 17; i++) exp_b[i] = wr ? wd : 8'h00;

        step();
        r0 = n_rise; c0 = n_cslow; d0 = n_done; v0 = n_rv;
        q0 = mosi_log.size(); g0 = n_glitch;
        cmd_write = wr; addr = a; wdata = wd; len = l; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " busy_on"}, busy, 1);
        chk({tag, " cs_low"}, cs_n, 0);
        chk({tag, " setup_sclk"}, sclk, 0);
        chk({tag, " setup_mosi"}, mosi, exp_b[0][7]);
        cmd_write = ~wr; addr = 8'($urandom); wdata = 8'($urandom); len = 4'($urandom);

        seen = 0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            step();
            if (poke && k == 60) start = 1'b1;
            if (poke && k == 61) start = 1'b0;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, seen, 1);
        step();
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " busy_off"}, busy, 0);
        chk({tag, " done_cnt"}, n_done - d0, 1);
        chk({tag, " sclk_rises"}, n_rise - r0, 8 * nb);
        chk({tag, " cs_low_cycles"}, n_cslow - c0, (2 + 16 * nb) * CLK_DIV);
        chk({tag, " mosi_stable"}, n_glitch - g0, 0);
        nrv = n_rv - v0;
        chk({tag, " rv_cnt"}, nrv, wr ? 0 : n);
        if (mosi_log.size() >= q0 + 8 * nb) begin
            for (int i = 0; i < nb; i++) begin
                got = 8'h00;
                for (int j = 0; j < 8; j++) got = {got[6:0], mosi_log[q0 + 8 * i + j]};
                chk($sformatf("%s mosi_byte%0d", tag, i), got, exp_b[i]);
            end
        end
        for (int i = 0; i < nrv && i < n; i++) begin
            chk($sformatf("%s rdata%0d", tag, i), rv_log[v0 + i], resp[2 + i]);
        end
        if (!wr) chk({tag, " rdata_last"}, rdata, resp[1 + n]);
    endtask

    initial begin
        int r0, d0, v0;
        bit reached;
        for (int i = 0; i < 17; i++) resp[i] = 8'h00;
        rst = 1'b1; start = 1'b0; cmd_write = 1'b0; addr = 8'h00; wdata = 8'h00; len = 4'd0;
        repeat (3) step();
        chk("rst cs_n", cs_n, 1);
        chk("rst sclk", sclk, 0);
        chk("rst mosi", mosi, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rv", rdata_valid, 0);
        chk("rst rdata", rdata, 8'h00);
        start = 1'b1; cmd_write = 1'b1;
        step();
        chk("rst_wins cs_n", cs_n, 1);
        chk("rst_wins busy", busy, 0);
        start = 1'b0;
        rst = 1'b0;
        step();

        run_txn(1'b1, 8'h2D, 8'h02, 4'd0, 1'b0, 8'h00, 1'b0, "wr2d");
        run_txn(1'b0, 8'h00, 8'h00, 4'd1, 1'b1, 8'hAD, 1'b0, "rd_len1");
        run_txn(1'b0, 8'h0E, 8'h00, 4'd6, 1'b1, 8'h11, 1'b0, "rd_len6");
        run_txn(1'b0, 8'h08, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, "rd_len0");
        run_txn(1'b1, 8'h1F, 8'h52, 4'd3, 1'b0, 8'h00, 1'b1, "wr_poke");
        run_txn(1'b0, 8'h10, 8'h00, 4'd15, 1'b0, 8'h00, 1'b1, "rd_len15_poke");

        // Abort at the 10th sclk rise.
        step();
        r0 = n_rise; d0 = n_done; v0 = n_rv;
        cmd_write = 1'b0; addr = 8'h33; len = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        reached = 0;
        for (int k = 0; k < 2000 && !reached; k++) begin
            step();
            if (n_rise - r0 >= 10) reached = 1;
        end
        chk("abort reached10", reached, 1);
        rst = 1'b1;
        step();
        chk("abort cs_n", cs_n, 1);
        chk("abort sclk", sclk, 0);
        chk("abort busy", busy, 0);
        step();
        rst = 1'b0;
        repeat (30) step();
        chk("abort no_done", n_done - d0, 0);
        chk("abort no_rv", n_rv - v0, 0);
        run_txn(1'b1, 8'h2C, 8'h13, 4'd0, 1'b0, 8'h00, 1'b0, "post_abort_wr");

        for (int t = 0; t < 16; t++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 8'h00,
                    1'($urandom), $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
